// File: rtl/lock_attempt_sequencer_if.sv
// Host/lock-side bundle for lock_attempt_sequencer.
//   i_start, iv_code, i_relock : host request side
//   iv_ack                     : acknowledge from the lock (bit 7 = unlocked)
//   o_CE, o_set_data, ov_data  : drive pins into the lock datapath
//   o_busy .. ov_fail_cnt      : status back to the host
// master = host/lock environment, slave = the sequencer.
interface lock_attempt_sequencer_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_FAILS  = 3
);
  localparam int FCW = $clog2(MAX_FAILS + 1);

  logic                    i_start;
  logic [4*NUM_DIGITS-1:0] iv_code;
  logic                    i_relock;
  logic [7:0]              iv_ack;
  logic                    o_CE;
  logic                    o_set_data;
  logic [3:0]              ov_data;
  logic                    o_busy;
  logic                    o_unlocked;
  logic                    o_lockout;
  logic                    o_pass;
  logic                    o_fail;
  logic [FCW-1:0]          ov_fail_cnt;

  modport master (
    output i_start, iv_code, i_relock, iv_ack,
    input  o_CE, o_set_data, ov_data, o_busy, o_unlocked, o_lockout,
           o_pass, o_fail, ov_fail_cnt
  );

  modport slave (
    input  i_start, iv_code, i_relock, iv_ack,
    output o_CE, o_set_data, ov_data, o_busy, o_unlocked, o_lockout,
           o_pass, o_fail, ov_fail_cnt
  );
endinterface

// File: rtl/lock_attempt_sequencer.sv
// Drives the combination-lock datapath for a host: captures a code on
// i_start, presents it one nibble at a time (SETUP_CYC hold, then a one-cycle
// strobe), waits up to CHECK_CYC cycles for the unlock acknowledge, counts
// consecutive failures and enforces a LOCKOUT_CYC lockout after MAX_FAILS.
// Ports: clk, i_Rst (sync, active high), bus (slave modport, see the
// interface file for the signal list). All outputs are decoded from
// registered state, so none depend combinationally on inputs.
module lock_attempt_sequencer #(
  parameter int NUM_DIGITS  = 4,
  parameter int SETUP_CYC   = 2,
  parameter int CHECK_CYC   = 8,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     i_Rst,
  lock_attempt_sequencer_if.slave  bus
);
  localparam int FCW   = $clog2(MAX_FAILS + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int T1    = (SETUP_CYC > CHECK_CYC) ? SETUP_CYC : CHECK_CYC;
  localparam int TMAX  = (LOCKOUT_CYC > T1) ? LOCKOUT_CYC : T1;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_CHECK, S_FAIL, S_UNLOCKED, S_LOCKOUT
  } state_t;

  state_t                  state, state_n;
  logic [4*NUM_DIGITS-1:0] code_q;
  logic [IDX_W-1:0]        idx;
  logic [TMR_W-1:0]        tmr;
  logic [FCW-1:0]          fail_cnt;
  logic                    pass_q;
  logic [3:0]              digit;
  logic                    ack_hit;
  logic                    unused_ack;

  assign ack_hit    = bus.iv_ack[7];
  assign unused_ack = ^bus.iv_ack[6:0];
  assign digit      = code_q[4*idx +: 4];

  // Next state and Moore outputs.
  always_comb begin
    state_n        = state;
    bus.o_CE       = 1'b0;
    bus.o_set_data = 1'b0;
    bus.ov_data    = 4'h0;
    bus.o_busy     = 1'b0;
    bus.o_unlocked = 1'b0;
    bus.o_lockout  = 1'b0;
    bus.o_fail     = 1'b0;
    case (state)
      S_IDLE: if (bus.i_start) state_n = S_SETUP;
      S_SETUP: begin
        bus.o_CE = 1'b1; bus.o_busy = 1'b1; bus.ov_data = digit;
        if (tmr == TMR_W'(SETUP_CYC - 1)) state_n = S_STROBE;
      end
      S_STROBE: begin
        bus.o_CE = 1'b1; bus.o_busy = 1'b1; bus.ov_data = digit;
        bus.o_set_data = 1'b1;
        state_n = (idx == LAST_IDX) ? S_CHECK : S_SETUP;
      end
      S_CHECK: begin
        // idx stays on the last digit, so ov_data keeps presenting it.
        bus.o_CE = 1'b1; bus.o_busy = 1'b1; bus.ov_data = digit;
        if (ack_hit)                             state_n = S_UNLOCKED;
        else if (tmr == TMR_W'(CHECK_CYC - 1))   state_n = S_FAIL;
      end
      S_FAIL: begin
        // fail_cnt already holds the incremented count in this cycle.
        bus.o_busy = 1'b1; bus.o_fail = 1'b1;
        state_n = (fail_cnt == FCW'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
      end
      S_UNLOCKED: begin
        bus.o_CE = 1'b1; bus.o_unlocked = 1'b1;
        if (bus.i_relock) state_n = S_IDLE;
      end
      S_LOCKOUT: begin
        bus.o_lockout = 1'b1;
        if (tmr == TMR_W'(LOCKOUT_CYC - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.o_pass      = pass_q;
  assign bus.ov_fail_cnt = fail_cnt;

  always_ff @(posedge clk) begin
    if (i_Rst) begin
      state    <= S_IDLE;
      code_q   <= '0;
      idx      <= '0;
      tmr      <= '0;
      fail_cnt <= '0;
      pass_q   <= 1'b0;
    end else begin
      state  <= state_n;
      pass_q <= (state == S_CHECK) && (state_n == S_UNLOCKED);
      // Shared dwell timer: restarts on every state change.
      if (state_n != state)
        tmr <= '0;
      else if (state == S_SETUP || state == S_CHECK || state == S_LOCKOUT)
        tmr <= tmr + 1'b1;
      if (state == S_IDLE && bus.i_start) begin
        code_q <= bus.iv_code;
        idx    <= '0;
      end
      if (state == S_STROBE && state_n == S_SETUP) idx <= idx + 1'b1;
      if (state == S_CHECK) begin
        if (state_n == S_UNLOCKED)  fail_cnt <= '0;
        else if (state_n == S_FAIL) fail_cnt <= fail_cnt + 1'b1;
      end
      if (state == S_LOCKOUT && state_n == S_IDLE) fail_cnt <= '0;
    end
  end
endmodule
